// File: rtl/rf_ldst_engine.sv
// Load/store engine: copies runs of RF lines between SDRAM (Avalon-MM master) and the RF RAM.
// Optional RF range check at command start is enabled by defining RF_LDST_BOUNDS_CHECK_EN.
module rf_ldst_engine #(
   parameter int RF_ADDR_W    = 10,
   parameter int SDRAM_ADDR_W = 32,
   parameter int LINE_NUM_W   = 8,
   parameter int LINE_W       = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_start,
   input  logic                    store_start,
   input  logic [RF_ADDR_W-1:0]    rf_addr,
   input  logic [SDRAM_ADDR_W-1:0] sdram_addr,
   input  logic [LINE_NUM_W-1:0]   line_num,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [RF_ADDR_W-1:0]    rf_ram_addr,
   output logic                    rf_ram_we,
   output logic [LINE_W-1:0]       rf_ram_wdata,
   input  logic [LINE_W-1:0]       rf_ram_rdata,
   output logic [SDRAM_ADDR_W-1:0] avm_address,
   output logic                    avm_read,
   output logic                    avm_write,
   output logic [LINE_W-1:0]       avm_writedata,
   input  logic                    avm_waitrequest,
   input  logic [LINE_W-1:0]       avm_readdata,
   input  logic                    avm_readdatavalid
);

   // Avalon handshake: a request (read/write) and its address/data are held
   // unchanged until a cycle in which waitrequest is low; that cycle accepts it.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      RF_RD   = 3'd3,
      RF_LAT  = 3'd4,
      WR_REQ  = 3'd5,
      FIN     = 3'd6
   } state_t;

   localparam int SUM_W = RF_ADDR_W + LINE_NUM_W + 1;

   state_t                  state_q;
   logic [RF_ADDR_W-1:0]    rf_addr_q;
   logic [SDRAM_ADDR_W-1:0] sd_addr_q;
   logic [LINE_NUM_W-1:0]   cnt_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    avm_read_q;
   logic                    avm_write_q;
   logic [SDRAM_ADDR_W-1:0] avm_address_q;
   logic [LINE_W-1:0]       avm_writedata_q;

   logic [RF_ADDR_W-1:0]    rf_addr_d;
   logic [SDRAM_ADDR_W-1:0] sd_addr_d;
   logic [LINE_NUM_W-1:0]   cnt_d;
   logic                    last_line;
   logic                    start;
   logic                    oob;

   assign rf_addr_d = rf_addr_q + RF_ADDR_W'(1);
   assign sd_addr_d = sd_addr_q + SDRAM_ADDR_W'(LINE_W / 8);
   assign cnt_d     = cnt_q - LINE_NUM_W'(1);
   assign last_line = (cnt_q == LINE_NUM_W'(1));
   assign start     = load_start | store_start;

`ifdef RF_LDST_BOUNDS_CHECK_EN
   logic [SUM_W-1:0] bound_sum;
   logic             err_q;

   assign bound_sum = SUM_W'(rf_addr) + SUM_W'(line_num);
   assign oob       = bound_sum > (SUM_W'(1) << RF_ADDR_W);
   assign err       = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         err_q <= oob;
      end
   end
`else
   assign oob = 1'b0;
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         rf_addr_q       <= '0;
         sd_addr_q       <= '0;
         cnt_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         avm_read_q      <= 1'b0;
         avm_write_q     <= 1'b0;
         avm_address_q   <= '0;
         avm_writedata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  rf_addr_q <= rf_addr;
                  sd_addr_q <= sdram_addr;
                  cnt_q     <= line_num;
                  busy_q    <= 1'b1;
                  if (line_num == '0 || oob) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end else if (load_start) begin
                     // Load has priority when both starts arrive together.
                     state_q       <= RD_REQ;
                     avm_read_q    <= 1'b1;
                     avm_address_q <= sdram_addr;
                  end else begin
                     state_q <= RF_RD;
                  end
               end
            end
            RD_REQ: begin
               if (!avm_waitrequest) begin
                  avm_read_q <= 1'b0;
                  state_q    <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (avm_readdatavalid) begin
                  rf_addr_q <= rf_addr_d;
                  sd_addr_q <= sd_addr_d;
                  cnt_q     <= cnt_d;
                  if (!last_line) begin
                     state_q       <= RD_REQ;
                     avm_read_q    <= 1'b1;
                     avm_address_q <= sd_addr_d;
                  end else begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end
               end
            end
            RF_RD: begin
               state_q <= RF_LAT;
            end
            RF_LAT: begin
               avm_writedata_q <= rf_ram_rdata;
               avm_address_q   <= sd_addr_q;
               avm_write_q     <= 1'b1;
               state_q         <= WR_REQ;
            end
            WR_REQ: begin
               if (!avm_waitrequest) begin
                  avm_write_q <= 1'b0;
                  rf_addr_q   <= rf_addr_d;
                  sd_addr_q   <= sd_addr_d;
                  cnt_q       <= cnt_d;
                  if (!last_line) begin
                     state_q <= RF_RD;
                  end else begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The RF write follows readdatavalid in the same cycle; a late beat after reset is dropped.
   assign rf_ram_we     = (state_q == RD_WAIT) && avm_readdatavalid;
   assign rf_ram_wdata  = rf_ram_we ? avm_readdata : '0;
   assign rf_ram_addr   = rf_addr_q;

   assign busy          = busy_q;
   assign done          = done_q;
   assign avm_read      = avm_read_q;
   assign avm_write     = avm_write_q;
   assign avm_address   = avm_address_q;
   assign avm_writedata = avm_writedata_q;

endmodule

// File: tb/tb_rf_ldst_engine.sv
// Directed bench for rf_ldst_engine: RF RAM model, Avalon slave model, checks by immediate assertions.
// Bounds-check expectations switch on RF_LDST_BOUNDS_CHECK_EN.
module tb_rf_ldst_engine;

   localparam int RF_ADDR_W    = 10;
   localparam int SDRAM_ADDR_W = 32;
   localparam int LINE_NUM_W   = 8;
   localparam int LINE_W       = 64;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    load_start = 1'b0;
   logic                    store_start = 1'b0;
   logic [RF_ADDR_W-1:0]    rf_addr = '0;
   logic [SDRAM_ADDR_W-1:0] sdram_addr = '0;
   logic [LINE_NUM_W-1:0]   line_num = '0;
   logic                    busy, done, err;
   logic [RF_ADDR_W-1:0]    rf_ram_addr;
   logic                    rf_ram_we;
   logic [LINE_W-1:0]       rf_ram_wdata;
   logic [LINE_W-1:0]       rf_ram_rdata = '0;
   logic [SDRAM_ADDR_W-1:0] avm_address;
   logic                    avm_read, avm_write;
   logic [LINE_W-1:0]       avm_writedata;
   logic                    avm_waitrequest;
   logic [LINE_W-1:0]       avm_readdata = '0;
   logic                    avm_readdatavalid = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rf_ldst_engine #(
      .RF_ADDR_W(RF_ADDR_W), .SDRAM_ADDR_W(SDRAM_ADDR_W),
      .LINE_NUM_W(LINE_NUM_W), .LINE_W(LINE_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .store_start(store_start),
      .rf_addr(rf_addr), .sdram_addr(sdram_addr), .line_num(line_num),
      .busy(busy), .done(done), .err(err),
      .rf_ram_addr(rf_ram_addr), .rf_ram_we(rf_ram_we),
      .rf_ram_wdata(rf_ram_wdata), .rf_ram_rdata(rf_ram_rdata),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // RF RAM model with 1-cycle read latency and a bench-side preload port.
   logic [LINE_W-1:0]    rf_mem [0:(1<<RF_ADDR_W)-1];
   logic                 poke_en = 1'b0;
   logic [RF_ADDR_W-1:0] poke_addr = '0;
   logic [LINE_W-1:0]    poke_data = '0;
   int                   we_cnt = 0;

   always @(posedge clk) begin
      if (poke_en) rf_mem[poke_addr] <= poke_data;
      if (rf_ram_we) begin
         rf_mem[rf_ram_addr] <= rf_ram_wdata;
         we_cnt <= we_cnt + 1;
      end
      rf_ram_rdata <= rf_mem[rf_ram_addr];
   end

   // Avalon slave: wait_cfg waitrequest cycles per request, read data one cycle after acceptance.
   int wait_cfg = 0;
   int wcnt = 0;
   int done_cnt = 0;
   logic [SDRAM_ADDR_W-1:0] rd_log [$];
   logic [SDRAM_ADDR_W-1:0] wa_log [$];
   logic [LINE_W-1:0]       wd_log [$];

   assign avm_waitrequest = (avm_read || avm_write) && (wcnt < wait_cfg);

   always @(posedge clk) begin
      avm_readdatavalid <= 1'b0;
      if (avm_read && !avm_waitrequest) begin
         avm_readdatavalid <= 1'b1;
         avm_readdata <= 64'hA0 + 64'((avm_address - 32'h1000) >> 3);
         rd_log.push_back(avm_address);
      end
      if (avm_write && !avm_waitrequest) begin
         wa_log.push_back(avm_address);
         wd_log.push_back(avm_writedata);
      end
      if ((avm_read || avm_write) && avm_waitrequest) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (done) done_cnt <= done_cnt + 1;
   end

   // Bus protocol monitor: stable request while stalled, read/write exclusive.
   logic                    held = 1'b0;
   logic [LINE_W-1:0]       h_data = '0;
   logic [SDRAM_ADDR_W-1:0] h_addr = '0;

   always @(negedge clk) begin
      if (held) begin
         check("wdata_stable", avm_writedata, h_data);
         check("addr_stable", avm_address, h_addr);
      end
      held   <= (avm_read || avm_write) && avm_waitrequest;
      h_data <= avm_writedata;
      h_addr <= avm_address;
      check("rd_wr_excl", avm_read && avm_write, 0);
   end

   task automatic poke(input logic [RF_ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic run_cmd(input logic ld, input logic st, input logic [RF_ADDR_W-1:0] ra,
                          input logic [SDRAM_ADDR_W-1:0] sa, input logic [LINE_NUM_W-1:0] n,
                          output int cyc, output logic busy0);
      @(negedge clk);
      rf_addr = ra; sdram_addr = sa; line_num = n;
      load_start = ld; store_start = st;
      cyc = 0; busy0 = 1'b0;
      do begin
         @(negedge clk);
         load_start = 1'b0; store_start = 1'b0;
         cyc++;
         if (cyc == 1) busy0 = busy;
      end while (!done && cyc < 300);
      check("done_timeout", cyc < 300, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_rd"}, avm_read, 0);
      check({tag, "_wr"}, avm_write, 0);
      check({tag, "_we"}, rf_ram_we, 0);
      check({tag, "_aaddr"}, avm_address, 0);
      check({tag, "_wdata"}, avm_writedata, 0);
      check({tag, "_raddr"}, rf_ram_addr, 0);
      check({tag, "_rwdata"}, rf_ram_wdata, 0);
   endtask

   initial begin
      int   cyc;
      logic b0;
      int   rd0, wr0, we0, dn0;

      // Reset
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // Load 4 lines
      dn0 = done_cnt; rd0 = rd_log.size(); we0 = we_cnt;
      run_cmd(1, 0, 10'h010, 32'h1000, 8'd4, cyc, b0);
      check("ld4_busy0", b0, 1);
      check("ld4_cycles", cyc, 9);
      check("ld4_nreads", rd_log.size() - rd0, 4);
      for (int i = 0; i < 4; i++) begin
         check("ld4_addr", rd_log[rd0 + i], 32'h1000 + 32'(8 * i));
         check("ld4_rf", rf_mem[10'h010 + 10'(i)], 64'hA0 + 64'(i));
      end
      check("ld4_we", we_cnt - we0, 4);
      @(negedge clk);
      check("ld4_done_once", done_cnt - dn0, 1);
      check("ld4_busy_fall", busy, 0);
      check("ld4_err", err, 0);

      // Store 3 lines across the RF wrap with 2 waitrequest cycles per write
      poke(10'h3FE, 64'h1111_2222_0000_00D0);
      poke(10'h3FF, 64'h3333_4444_0000_00D1);
      poke(10'h000, 64'h5555_6666_0000_00D2);
      wait_cfg = 2;
      wr0 = wa_log.size(); rd0 = rd_log.size(); dn0 = done_cnt;
      run_cmd(0, 1, 10'h3FE, 32'h2000, 8'd3, cyc, b0);
      check("st3_busy0", b0, 1);
`ifdef RF_LDST_BOUNDS_CHECK_EN
      check("oob_cycles", cyc, 1);
      check("oob_err", err, 1);
      check("oob_nwrites", wa_log.size() - wr0, 0);
      check("oob_nreads", rd_log.size() - rd0, 0);
      @(negedge clk);
      check("oob_err_sticky", err, 1);
      wait_cfg = 0;
      run_cmd(1, 0, 10'h060, 32'h1008, 8'd1, cyc, b0);
      check("oob_clear_err", err, 0);
      check("oob_clear_rf", rf_mem[10'h060], 64'hA1);
`else
      check("st3_cycles", cyc, 16);
      check("st3_nwrites", wa_log.size() - wr0, 3);
      check("st3_nreads", rd_log.size() - rd0, 0);
      check("st3_wa0", wa_log[wr0], 32'h2000);
      check("st3_wa1", wa_log[wr0 + 1], 32'h2008);
      check("st3_wa2", wa_log[wr0 + 2], 32'h2010);
      check("st3_wd0", wd_log[wr0], 64'h1111_2222_0000_00D0);
      check("st3_wd1", wd_log[wr0 + 1], 64'h3333_4444_0000_00D1);
      check("st3_wd2", wd_log[wr0 + 2], 64'h5555_6666_0000_00D2);
      check("st3_err", err, 0);
`endif
      wait_cfg = 0;
      @(negedge clk);
      check("st3_done_once", done_cnt - dn0, 1);

      // N = 0
      rd0 = rd_log.size(); we0 = we_cnt;
      run_cmd(1, 0, 10'h070, 32'h1000, 8'd0, cyc, b0);
      check("n0_cycles", cyc, 1);
      check("n0_busy", b0, 1);
      @(negedge clk);
      check("n0_nreads", rd_log.size() - rd0, 0);
      check("n0_we", we_cnt - we0, 0);
      check("n0_busy_fall", busy, 0);

      // Both starts together: load wins
      rd0 = rd_log.size(); wr0 = wa_log.size();
      run_cmd(1, 1, 10'h020, 32'h1000, 8'd1, cyc, b0);
      check("both_cycles", cyc, 3);
      check("both_nreads", rd_log.size() - rd0, 1);
      check("both_nwrites", wa_log.size() - wr0, 0);
      check("both_rf", rf_mem[10'h020], 64'hA0);

      // store_start while busy is ignored
      @(negedge clk);
      rd0 = rd_log.size(); wr0 = wa_log.size(); dn0 = done_cnt;
      rf_addr = 10'h030; sdram_addr = 32'h1010; line_num = 8'd2; load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0; store_start = 1'b1;
      @(negedge clk);
      store_start = 1'b0;
      cyc = 2;
      while (!done && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check("busy_st_timeout", cyc < 300, 1);
      check("busy_st_cycles", cyc, 5);
      @(negedge clk);
      repeat (4) @(negedge clk);
      check("busy_st_nwrites", wa_log.size() - wr0, 0);
      check("busy_st_nreads", rd_log.size() - rd0, 2);
      check("busy_st_rf0", rf_mem[10'h030], 64'hA2);
      check("busy_st_rf1", rf_mem[10'h031], 64'hA3);
      check("busy_st_done", done_cnt - dn0, 1);

      // Reset during RD_WAIT of line 2 of 4
      poke(10'h041, 64'hDEAD);
      dn0 = done_cnt;
      @(negedge clk);
      rf_addr = 10'h040; sdram_addr = 32'h1000; line_num = 8'd4; load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_we", rf_ram_we, 1);
      check("rst_mid_raddr", rf_ram_addr, 10'h041);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      repeat (2) @(negedge clk);
      check_idle_outputs("rst_hold");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_no_done", done_cnt - dn0, 0);
      check("rst_rf0", rf_mem[10'h040], 64'hA0);
      check("rst_rf1", rf_mem[10'h041], 64'hDEAD);
      run_cmd(1, 0, 10'h050, 32'h1018, 8'd1, cyc, b0);
      check("rst_after_cycles", cyc, 3);
      @(negedge clk);
      check("rst_after_rf", rf_mem[10'h050], 64'hA3);
      check("rst_after_done", done_cnt - dn0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
